// File: rtl/pipe_mem_responder_pkg.sv
// Shared constants and types for the pipeline-side RAM responder.
package pipe_mem_pkg;

  localparam int unsigned PIPE_WIN_BIT = 29;
  localparam int unsigned READ_LAT     = 2;
  localparam int unsigned CORE_W       = 32;

  // Which port a read in flight belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_PKT  = 2'd2
  } owner_e;

  // Tag travelling alongside a read; zero marks a core rd+wr slot whose read was dropped
  typedef struct packed {
    owner_e owner;
    logic   zero;
  } rd_tag_t;

  // Core request lands in the pipeline RAM window
  function automatic logic is_pipe_hit(input logic req, input logic [CORE_W-1:0] addr);
    return req && addr[PIPE_WIN_BIT];
  endfunction

endpackage

// File: rtl/pipe_mem_responder_sram.sv
// Single-port word SRAM with 1-cycle synchronous read; array is never reset.
module pipe_mem_sram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // One access per cycle: write wins, otherwise read into the data register
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pipe_mem_responder.sv
// Shares a local SRAM between the stall-free core (absolute priority, fixed 2-cycle
// read latency) and the packet pipeline (valid/ready requests, 1-cycle response pulse).
module pipe_mem_responder
  import pipe_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_rden,
  input  logic                    core_wren,
  input  logic [31:0]             core_addr,
  input  logic [31:0]             core_wdata,
  output logic [31:0]             core_rdata,
  input  logic                    pkt_req_valid,
  output logic                    pkt_req_ready,
  input  logic                    pkt_req_wr,
  input  logic [ADDR_W-1:0]       pkt_req_addr,
  input  logic [DATA_W-1:0]       pkt_req_wdata,
  output logic                    pkt_rsp_valid,
  output logic [DATA_W-1:0]       pkt_rsp_rdata,
  output logic [STARVE_CNT_W-1:0] starve_cnt
);

  localparam int unsigned TAG_DEPTH = READ_LAT - 1;

  logic              w_core_hit_rd;
  logic              w_core_hit_wr;
  logic              w_core_hit;
  logic              w_pkt_acc;
  logic              w_sram_we;
  logic              w_sram_re;
  logic [ADDR_W-1:0] w_sram_addr;
  logic [DATA_W-1:0] w_sram_wdata;
  logic [DATA_W-1:0] w_sram_rdata;
  rd_tag_t           w_tag_nxt;
  logic              w_unused_addr;

  rd_tag_t                 r_tag [TAG_DEPTH];
  logic [31:0]             r_core_rdata;
  logic [DATA_W-1:0]       r_pkt_rdata;
  logic                    r_pkt_rsp_valid;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  // Hit decode: loads outside the window (DTCM) never touch the SRAM
  assign w_core_hit_rd = is_pipe_hit(core_rden, core_addr);
  assign w_core_hit_wr = is_pipe_hit(core_wren, core_addr);
  assign w_core_hit    = w_core_hit_rd || w_core_hit_wr;

  // Ready depends only on core inputs so the pipeline can never combinationally loop
  assign pkt_req_ready = !w_core_hit;
  assign w_pkt_acc     = pkt_req_valid && pkt_req_ready;

  // A core rd+wr slot performs only the write
  assign w_sram_we    = w_core_hit_wr || (w_pkt_acc && pkt_req_wr);
  assign w_sram_re    = (w_core_hit_rd && !w_core_hit_wr) || (w_pkt_acc && !pkt_req_wr);
  assign w_sram_addr  = w_core_hit ? core_addr[ADDR_W-1:0] : pkt_req_addr;
  assign w_sram_wdata = w_core_hit_wr ? DATA_W'(core_wdata) : pkt_req_wdata;

  // Upper word-address bits alias away: the window is mirrored modulo depth
  assign w_unused_addr = ^{core_addr[31:PIPE_WIN_BIT+1], core_addr[PIPE_WIN_BIT-1:ADDR_W]};

  // Tag for the read launched this cycle
  always_comb begin
    w_tag_nxt       = '0;
    w_tag_nxt.owner = OWN_NONE;
    if (w_core_hit_rd) begin
      w_tag_nxt.owner = OWN_CORE;
      w_tag_nxt.zero  = w_core_hit_wr;
    end else if (w_pkt_acc && !pkt_req_wr) begin
      w_tag_nxt.owner = OWN_PKT;
    end
  end

  pipe_mem_sram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_re    (w_sram_re),
    .i_addr  (w_sram_addr),
    .i_wdata (w_sram_wdata),
    .o_rdata (w_sram_rdata)
  );

  // Owner tags follow the SRAM read stage; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_nxt;
      for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Output stage: route read data to its owner, each side holds its last value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_rdata    <= '0;
      r_pkt_rdata     <= '0;
      r_pkt_rsp_valid <= 1'b0;
    end else begin
      r_pkt_rsp_valid <= (r_tag[TAG_DEPTH-1].owner == OWN_PKT);
      if (r_tag[TAG_DEPTH-1].owner == OWN_CORE) begin
        r_core_rdata <= r_tag[TAG_DEPTH-1].zero ? 32'h0 : 32'(w_sram_rdata);
      end
      if (r_tag[TAG_DEPTH-1].owner == OWN_PKT) begin
        r_pkt_rdata <= w_sram_rdata;
      end
    end
  end

  // Saturating count of cycles the pipeline was held off by the core
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (pkt_req_valid && !pkt_req_ready && (r_starve_cnt != '1)) begin
      r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
    end
  end

  assign core_rdata    = r_core_rdata;
  assign pkt_rsp_valid = r_pkt_rsp_valid;
  assign pkt_rsp_rdata = r_pkt_rdata;
  assign starve_cnt    = r_starve_cnt;

endmodule

// File: tb/tb_pipe_mem_responder.sv
// Self-checking bench: vector table plus hand sequences, reads checked via a scoreboard.
module tb_pipe_mem_responder;
  import pipe_mem_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_rden, core_wren;
  logic [31:0]   core_addr, core_wdata, core_rdata;
  logic          pkt_req_valid, pkt_req_ready, pkt_req_wr;
  logic [AW-1:0] pkt_req_addr;
  logic [DW-1:0] pkt_req_wdata;
  logic          pkt_rsp_valid;
  logic [DW-1:0] pkt_rsp_rdata;
  logic [SW-1:0] starve_cnt;

  always #5 clk = ~clk;

  pipe_mem_responder #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_CNT_W (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_rden     (core_rden),
    .core_wren     (core_wren),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_rdata    (core_rdata),
    .pkt_req_valid (pkt_req_valid),
    .pkt_req_ready (pkt_req_ready),
    .pkt_req_wr    (pkt_req_wr),
    .pkt_req_addr  (pkt_req_addr),
    .pkt_req_wdata (pkt_req_wdata),
    .pkt_rsp_valid (pkt_rsp_valid),
    .pkt_rsp_rdata (pkt_rsp_rdata),
    .starve_cnt    (starve_cnt)
  );

  typedef struct {
    logic          rden;
    logic          wren;
    logic [31:0]   caddr;
    logic [31:0]   cwdata;
    logic          pv;
    logic          pwr;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic          exp_rdy;
  } vec_t;

  typedef struct {
    int          due;
    logic        is_pkt;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] mdl_mem [2**AW];
  logic [31:0] exp_core, exp_pkt;
  logic [SW-1:0] exp_starve;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic rden, input logic wren, input logic [31:0] caddr,
                              input logic [31:0] cwdata, input logic pv, input logic pwr,
                              input logic [AW-1:0] paddr, input logic [31:0] pwdata,
                              input logic rdy);
    vec_t v;
    v.rden = rden; v.wren = wren; v.caddr = caddr; v.cwdata = cwdata;
    v.pv = pv; v.pwr = pwr; v.paddr = paddr; v.pwdata = pwdata; v.exp_rdy = rdy;
    return v;
  endfunction

  // Compare all outputs against the scoreboard after each clock edge
  task automatic monitor();
    logic exp_valid;
    exp_t e;
    exp_valid = 1'b0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.is_pkt) begin
        exp_valid = 1'b1;
        exp_pkt   = e.data;
      end else begin
        exp_core = e.data;
      end
    end
    chk("pkt_rsp_valid", 32'(pkt_rsp_valid), 32'(exp_valid));
    chk("core_rdata", core_rdata, exp_core);
    chk("pkt_rsp_rdata", pkt_rsp_rdata, exp_pkt);
    chk("starve_cnt", 32'(starve_cnt), 32'(exp_starve));
  endtask

  // Drive one cycle, check ready, update memory model and scoreboard
  task automatic step(input vec_t v);
    logic hit_rd, hit_wr;
    core_rden = v.rden; core_wren = v.wren; core_addr = v.caddr; core_wdata = v.cwdata;
    pkt_req_valid = v.pv; pkt_req_wr = v.pwr; pkt_req_addr = v.paddr; pkt_req_wdata = v.pwdata;
    #1;
    chk("pkt_req_ready", 32'(pkt_req_ready), 32'(v.exp_rdy));
    hit_rd = v.rden && v.caddr[PIPE_WIN_BIT];
    hit_wr = v.wren && v.caddr[PIPE_WIN_BIT];
    if (hit_rd)
      sb.push_back('{cyc + int'(READ_LAT), 1'b0, hit_wr ? 32'h0 : mdl_mem[v.caddr[AW-1:0]]});
    else if (v.pv && !hit_wr && !v.pwr)
      sb.push_back('{cyc + int'(READ_LAT), 1'b1, mdl_mem[v.paddr]});
    if (hit_wr) mdl_mem[v.caddr[AW-1:0]] = v.cwdata;
    else if (v.pv && !hit_rd && v.pwr) mdl_mem[v.paddr] = v.pwdata;
    if (v.pv && (hit_rd || hit_wr) && exp_starve != '1) exp_starve = exp_starve + SW'(1);
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    core_rden = 1'b0; core_wren = 1'b0; core_addr = '0; core_wdata = '0;
    pkt_req_valid = 1'b0; pkt_req_wr = 1'b0; pkt_req_addr = '0; pkt_req_wdata = '0;
    @(posedge clk);
    #1;
    cyc++;
    sb.delete();
    exp_core = '0; exp_pkt = '0; exp_starve = '0;
    monitor();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 32'h0, 32'h0, 0, 0, '0, 32'h0, 1);
    for (int i = 0; i < 2**AW; i++) mdl_mem[i] = '0;
    exp_core = '0; exp_pkt = '0; exp_starve = '0;

    // Vector table: arbitration, back-to-back reads, aliasing, rd+wr collision
    vecs.push_back(mk(1, 0, 32'h2000_0004, 32'h0,  1, 1, 10'd5, 32'h1234, 0));
    vecs.push_back(mk(0, 0, 32'h0,         32'h0,  1, 1, 10'd5, 32'h1234, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, AW'(i), 32'hA0 + 32'(i), 1));
    vecs.push_back(mk(1, 0, 32'h0000_0004, 32'h0,  1, 0, 10'd5, 32'h0, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 0, AW'(i), 32'h0, 1));
    vecs.push_back(mk(0, 1, 32'h2000_0400, 32'h55, 1, 0, 10'd1, 32'h0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         32'h0,  1, 0, 10'd0, 32'h0, 1));
    vecs.push_back(mk(1, 1, 32'h2000_0002, 32'h77, 0, 0, 10'd0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h2000_0002, 32'h0,  0, 0, 10'd0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h2000_0005, 32'h0,  0, 0, 10'd0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         32'h0,  1, 0, 10'd2, 32'h0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(idle);

    reset = 1'b1;
    core_rden = 1'b0; core_wren = 1'b0; core_addr = '0; core_wdata = '0;
    pkt_req_valid = 1'b0; pkt_req_wr = 1'b0; pkt_req_addr = '0; pkt_req_wdata = '0;
    @(posedge clk);
    do_reset();

    // Core write then read in the window: data appears exactly two cycles later
    step(mk(0, 1, 32'h2000_0004, 32'hDEAD_BEEF, 0, 0, '0, 32'h0, 0));
    step(mk(1, 0, 32'h2000_0004, 32'h0,         0, 0, '0, 32'h0, 0));
    chk("t1 core_rdata before latency", core_rdata, 32'h0);
    step(idle);
    chk("t1 core_rdata", core_rdata, 32'hDEAD_BEEF);
    chk("t1 no pkt rsp", 32'(pkt_rsp_valid), 32'h0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset one cycle after an accepted pkt read: response dropped, SRAM kept
    step(mk(0, 0, 32'h0, 32'h0, 1, 0, 10'd1, 32'h0, 1));
    do_reset();
    chk("t5 starve after reset", 32'(starve_cnt), 32'h0);
    for (int i = 0; i < 3; i++) step(idle);
    step(mk(0, 0, 32'h0, 32'h0, 1, 0, 10'd1, 32'h0, 1));
    step(idle);
    chk("t5 rsp_valid", 32'(pkt_rsp_valid), 32'h1);
    chk("t5 pkt_rsp_rdata", pkt_rsp_rdata, 32'hA1);

    // Starvation counter saturates instead of wrapping
    for (int i = 0; i < 20; i++) step(mk(1, 0, 32'h2000_0000, 32'h0, 1, 0, 10'd7, 32'h0, 0));
    chk("t6 starve saturated", 32'(starve_cnt), 32'd15);
    for (int i = 0; i < 3; i++) step(idle);
    chk("t6 starve holds", 32'(starve_cnt), 32'd15);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
